// File: rtl/sample_fifo.sv
// Sample buffer between the ADC capture logic and the SPI output shifter.
// Register-based FIFO. The head sample is presented combinationally so the shifter can
// load it in the same cycle it pops. Overflow or an explicit resync request flushes the
// buffer and raises a registered one-cycle resync pulse so the shifter can realign.
module sample_fifo #(
  parameter int unsigned             SAMPLE_WIDTH   = 16,
  parameter int unsigned             DEPTH          = 16,
  parameter logic [SAMPLE_WIDTH-1:0] UNDERFLOW_WORD = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [SAMPLE_WIDTH-1:0]   in_data,
  input  logic                      out_ready,
  output logic [SAMPLE_WIDTH-1:0]   out_data,
  input  logic                      resync_req,
  output logic                      resync,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      flag_clr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            resync_q, resync_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic            ovf_evt;
  logic            unf_evt;
  logic            flush;
  logic            push;
  logic            pop;
  logic            mem_we;
  logic [PtrW-1:0] mem_waddr;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);

  // Decode this cycle's events from the registered state and the request inputs.
  always_comb begin
    // A pop while full makes room, so only a push with no pop is an overflow.
    ovf_evt = in_valid & full & ~out_ready;
    flush   = resync_req | ovf_evt;
    // A resync request swallows a same-cycle pop, so it can never underflow.
    unf_evt = out_ready & empty & ~resync_req;
    pop     = out_ready & ~empty & ~flush;
    push    = in_valid & ~flush & (~full | pop);
    // After a flush the incoming sample lands in slot 0 as the sole entry.
    mem_we    = flush ? in_valid : push;
    mem_waddr = flush ? '0 : wr_ptr_q;
  end

  // Next-state for pointers, occupancy and the status flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = in_valid ? PtrOne : '0;
      count_d  = in_valid ? CntOne : '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (push && !pop) begin
        count_d = count_q + CntOne;
      end else if (pop && !push) begin
        count_d = count_q - CntOne;
      end
    end
    resync_d    = flush;
    // A new error in the same cycle as a clear wins.
    overflow_d  = ovf_evt | (overflow_q & ~flag_clr);
    underflow_d = unf_evt | (underflow_q & ~flag_clr);
  end

  // Control state; reset discards contents without producing a resync pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      resync_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      resync_q    <= resync_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Sample storage; contents are don't-care after reset so the array is not reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= in_data;
    end
  end

  // Head is not bypassed: a word pushed into an empty FIFO shows up the next cycle.
  assign out_data  = empty ? UNDERFLOW_WORD : mem[rd_ptr_q];
  assign count     = count_q;
  assign resync    = resync_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Randomised and directed bench for sample_fifo with a queue-based reference model.
// The driver pushes per-cycle expected state and expected popped words; a negedge
// monitor pops and compares them against the DUT.
module tb_sample_fifo;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D) + 1;
  localparam logic [W-1:0] UW = 16'hDEAD;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          resync_req;
  logic          resync;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
  logic          flag_clr;

  sample_fifo #(
    .SAMPLE_WIDTH  (W),
    .DEPTH         (D),
    .UNDERFLOW_WORD(UW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_data  (out_data),
    .resync_req(resync_req),
    .resync    (resync),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .flag_clr  (flag_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    logic [W-1:0] dout;
    bit          rs;
    bit          ov;
    bit          un;
  } exp_t;

  exp_t         st_q[$];
  logic [W-1:0] pop_q[$];
  logic [W-1:0] model_q[$];
  bit           m_rs, m_ov, m_un;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the DUT's visible state and any accepted pop against the model.
  always @(negedge clk) begin
    exp_t e;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      check("count", 32'(count), 32'(e.cnt));
      check("empty", 32'(empty), 32'(e.cnt == 0));
      check("full", 32'(full), 32'(e.cnt == int'(D)));
      check("out_data", 32'(out_data), 32'(e.dout));
      check("resync", 32'(resync), 32'(e.rs));
      check("overflow", 32'(overflow), 32'(e.ov));
      check("underflow", 32'(underflow), 32'(e.un));
    end
    if (!rst && out_ready && !empty && !resync_req) begin
      if (pop_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
      else check("pop_data", 32'(out_data), 32'(pop_q.pop_front()));
    end
  end

  // One clock of stimulus: record the current model state, then advance the model.
  task automatic cyc(bit iv, logic [W-1:0] d, bit ordy, bit rreq = 1'b0, bit fclr = 1'b0);
    exp_t e;
    bit   mfull, mempty, ovf, unf;
    in_valid   = iv;
    in_data    = d;
    out_ready  = ordy;
    resync_req = rreq;
    flag_clr   = fclr;
    e.cnt  = model_q.size();
    e.dout = UW;
    if (model_q.size() > 0) e.dout = model_q[0];
    e.rs = m_rs;
    e.ov = m_ov;
    e.un = m_un;
    st_q.push_back(e);
    mfull  = (model_q.size() == D);
    mempty = (model_q.size() == 0);
    ovf    = iv && mfull && !ordy;
    unf    = ordy && mempty && !rreq;
    if (rreq || ovf) begin
      model_q.delete();
      if (iv) model_q.push_back(d);
    end else begin
      if (ordy && !mempty) pop_q.push_back(model_q.pop_front());
      if (iv) model_q.push_back(d);
    end
    m_rs = rreq || ovf;
    m_ov = ovf || (m_ov && !fclr);
    m_un = unf || (m_un && !fclr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    resync_req = 1'b0;
    flag_clr   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    m_rs = 1'b0;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  initial begin
    do_reset();
    cyc(0, '0, 0);

    // In-order push then pop.
    cyc(1, 16'h1111, 0);
    cyc(1, 16'h2222, 0);
    cyc(1, 16'h3333, 0);
    repeat (3) cyc(0, '0, 1);
    cyc(0, '0, 0);

    // Overflow from full: flush, keep the new sample, pulse resync once.
    for (int i = 0; i < 4; i++) cyc(1, 16'hA0 + 16'(i), 0);
    cyc(1, 16'hA4, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 1);
    cyc(0, '0, 0);

    // Full with simultaneous push and pop, wrapping the pointers.
    for (int i = 0; i < 4; i++) cyc(1, 16'hB0 + 16'(i), 0);
    for (int i = 0; i < 10; i++) cyc(1, 16'hB4 + 16'(i), 1);
    repeat (4) cyc(0, '0, 1);

    // Underflow and sticky clear, including set-wins-over-clear.
    cyc(0, '0, 1);
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 1, 0, 1);
    cyc(0, '0, 0);
    cyc(0, '0, 0, 0, 1);

    // Resync request with push and pop at count 3.
    cyc(1, 16'hC1, 0);
    cyc(1, 16'hC2, 0);
    cyc(1, 16'hC3, 0);
    cyc(1, 16'hC5, 1, 1);
    cyc(0, '0, 0);
    cyc(0, '0, 1);

    // Reset mid-operation.
    cyc(1, 16'hD1, 0);
    cyc(1, 16'hD2, 0);
    cyc(0, '0, 0);
    do_reset();
    cyc(0, '0, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(bit'($urandom_range(0, 1)), W'($urandom()), bit'($urandom_range(0, 2) == 0),
          bit'($urandom_range(0, 40) == 0), bit'($urandom_range(0, 15) == 0));
    end
    cyc(0, '0, 0);
    @(negedge clk);
    check("pop_q_drained", 32'(pop_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
